// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
//   Shared definitions for the instruction-fetch stage: bus widths, pipeline
//   hold levels, jump/reset polarities, the NOP encoding and the record that
//   travels from the instruction bus to the IF/ID registers.
// -----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int HOLD_FLAG_W = 3;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;
    typedef logic [HOLD_FLAG_W-1:0] hold_flag_t;

    // Pipeline hold levels; a level at or above HOLD_IF freezes the IF/ID regs.
    localparam hold_flag_t HOLD_NONE = 3'b000;
    localparam hold_flag_t HOLD_PC   = 3'b001;
    localparam hold_flag_t HOLD_IF   = 3'b010;
    localparam hold_flag_t HOLD_ID   = 3'b011;

    localparam logic JUMP_ENABLE = 1'b1;
    // Reset level; the reset input of this stage is active-low.
    localparam logic RST_ENABLE  = 1'b0;

    // addi x0, x0, 0
    localparam inst_t INST_NOP = 32'h0000_0013;

    // One completed fetch: data, the address it was fetched from, bus error.
    typedef struct packed {
        inst_t      inst;
        inst_addr_t addr;
        logic       err;
    } fetch_resp_t;

endpackage : if_fetch_pkg

// File: rtl/if_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO with a flush, used for the in-flight address queue
//   and for the response buffer of the fetch stage. The head entry is always
//   visible on dout (show-ahead), so a pop consumes what the reader already saw.
//
// Ports
//   clk    in   clock
//   rst    in   asynchronous reset, active-low
//   flush  in   empty the FIFO at the next edge (wins over push/pop)
//   push   in   write din at the tail
//   din    in   WIDTH-bit write data
//   pop    in   drop the head entry
//   dout   out  head entry (undefined content while empty)
//   count  out  number of stored entries
//   empty  out  count == 0
//   full   out  count == DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & ~flush & (~full | pop);
    assign do_pop  = pop & ~flush & ~empty;
    assign dout    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count decide what
    // is valid, so resetting the data would only cost flops and reset routing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule : fetch_fifo

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage sitting right after the PC register. Every PC value
//   is offered as a read on the instruction bus; up to MAX_OUTST reads may be in
//   flight. In-order responses are either written straight into the IF/ID
//   registers or parked in a response buffer while decode holds. A jump kills
//   all in-flight work: responses still on the bus are counted and discarded.
//
// Ports
//   clk            in   clock
//   rst            in   asynchronous reset, active-low
//   pc_i           in   current PC from the PC register
//   jump_flag_i    in   jump/flush request
//   hold_flag_i    in   pipeline hold level
//   ibus_req_o     out  read request
//   ibus_addr_o    out  read address (always pc_i)
//   ibus_gnt_i     in   request accepted this cycle
//   ibus_rvalid_i  in   in-order read response valid
//   ibus_rdata_i   in   read response data
//   ibus_err_i     in   bus error, qualified by ibus_rvalid_i
//   stall_req_o    out  hold the PC this cycle (combinational)
//   inst_o         out  instruction to decode
//   inst_addr_o    out  address of inst_o
//   inst_valid_o   out  inst_o is a real fetched instruction
//   inst_err_o     out  fetch of inst_o returned a bus error
// -----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int              MAX_OUTST = 2,
    parameter logic [INST_W-1:0] NOP_INST = INST_NOP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic                   jump_flag_i,
    input  logic [HOLD_FLAG_W-1:0] hold_flag_i,
    output logic                   ibus_req_o,
    output logic [INST_ADDR_W-1:0] ibus_addr_o,
    input  logic                   ibus_gnt_i,
    input  logic                   ibus_rvalid_i,
    input  logic [INST_W-1:0]      ibus_rdata_i,
    input  logic                   ibus_err_i,
    output logic                   stall_req_o,
    output logic [INST_W-1:0]      inst_o,
    output logic [INST_ADDR_W-1:0] inst_addr_o,
    output logic                   inst_valid_o,
    output logic                   inst_err_o
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    // Wide enough to add three CW-bit counters without wrapping.
    localparam int SW = CW + 2;

    // Reads granted whose responses will be delivered / discarded.
    logic [CW-1:0] outst_q;
    logic [CW-1:0] drop_q;

    logic [SW-1:0] occ;
    logic          jump;
    logic          grant;
    logic          advance;
    logic          drop_rsp;
    logic          keep_rsp;

    logic [INST_ADDR_W-1:0] addr_head;
    logic [CW-1:0]          addr_count;
    logic                   addr_empty;
    logic                   addr_full;

    fetch_resp_t   rsp_new;
    fetch_resp_t   buf_head;
    logic [CW-1:0] buf_count;
    logic          buf_empty;
    logic          buf_full;
    logic          buf_push;
    logic          buf_pop;
    logic          bypass;

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------
    // Discarded reads still occupy bus slots until their responses return,
    // so they count against the limit just like live ones.
    assign occ   = SW'(outst_q) + SW'(drop_q) + SW'(buf_count);
    assign jump  = (jump_flag_i == JUMP_ENABLE);

    assign ibus_req_o  = (rst != RST_ENABLE) & ~jump & (occ < SW'(MAX_OUTST));
    assign ibus_addr_o = pc_i;
    assign grant       = ibus_req_o & ibus_gnt_i;

    // The PC moves only when its value was taken by the bus, or on a jump so
    // it can load the target.
    assign stall_req_o = ~jump & ~grant;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    assign advance  = (hold_flag_i < HOLD_IF);
    assign drop_rsp = ibus_rvalid_i & (drop_q != '0);
    assign keep_rsp = ibus_rvalid_i & (drop_q == '0);

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rsp_new  = '{inst: ibus_rdata_i, addr: addr_head, err: ibus_err_i};
        bypass   = 1'b0;
        buf_push = 1'b0;
        buf_pop  = 1'b0;
        if (advance && !buf_empty) begin
            buf_pop = 1'b1;
        end
        if (keep_rsp) begin
            // Skip the buffer only when nothing older is waiting in it.
            if (advance && buf_empty) bypass   = 1'b1;
            else                      buf_push = 1'b1;
        end
    end

    // Address queue: every granted read, live or discarded, in bus order.
    fetch_fifo #(
        .WIDTH (INST_ADDR_W),
        .DEPTH (MAX_OUTST)
    ) u_addr_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (grant),
        .din   (pc_i),
        .pop   (ibus_rvalid_i),
        .dout  (addr_head),
        .count (addr_count),
        .empty (addr_empty),
        .full  (addr_full)
    );

    // Completed fetches waiting for decode to release its hold.
    fetch_fifo #(
        .WIDTH ($bits(fetch_resp_t)),
        .DEPTH (MAX_OUTST)
    ) u_resp_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (jump),
        .push  (buf_push),
        .din   (rsp_new),
        .pop   (buf_pop),
        .dout  (buf_head),
        .count (buf_count),
        .empty (buf_empty),
        .full  (buf_full)
    );

    // ------------------------------------------------------------------
    // Outstanding / discard counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outst_q <= '0;
            drop_q  <= '0;
        end else if (jump) begin
            // Everything still on the bus becomes a discard, less whatever
            // response returns in this very cycle.
            outst_q <= '0;
            drop_q  <= drop_q - CW'(drop_rsp) + outst_q - CW'(keep_rsp);
        end else begin
            outst_q <= outst_q + CW'(grant) - CW'(keep_rsp);
            if (drop_rsp) drop_q <= drop_q - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // IF/ID registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_o       <= NOP_INST;
            inst_addr_o  <= '0;
            inst_valid_o <= 1'b0;
            inst_err_o   <= 1'b0;
        end else if (jump) begin
            // A jump squashes the register even while decode is holding.
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
            inst_err_o   <= 1'b0;
        end else if (advance) begin
            if (!buf_empty) begin
                inst_o       <= buf_head.inst;
                inst_addr_o  <= buf_head.addr;
                inst_valid_o <= 1'b1;
                inst_err_o   <= buf_head.err;
            end else if (bypass) begin
                inst_o       <= rsp_new.inst;
                inst_addr_o  <= rsp_new.addr;
                inst_valid_o <= 1'b1;
                inst_err_o   <= rsp_new.err;
            end else begin
                // Bubble; the address is left as is.
                inst_o       <= NOP_INST;
                inst_valid_o <= 1'b0;
                inst_err_o   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol and consistency checks
    // ------------------------------------------------------------------
    a_rvalid_expected : assert property (@(posedge clk) disable iff (!rst)
        ibus_rvalid_i |-> ((SW'(outst_q) + SW'(drop_q)) != '0) && !addr_empty);

    a_addr_count : assert property (@(posedge clk) disable iff (!rst)
        SW'(addr_count) == SW'(outst_q) + SW'(drop_q));

    a_addr_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        grant |-> !addr_full || ibus_rvalid_i);

    a_buf_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        (buf_push && !jump) |-> !buf_full || buf_pop);

endmodule : if_fetch

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] XD  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        jump_flag;
    logic [2:0]  hold_flag;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        ibus_err;
    logic        stall_req;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic        inst_err;

    always #5 clk = ~clk;

    if_fetch #(
        .MAX_OUTST (2),
        .NOP_INST  (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc),
        .jump_flag_i   (jump_flag),
        .hold_flag_i   (hold_flag),
        .ibus_req_o    (ibus_req),
        .ibus_addr_o   (ibus_addr),
        .ibus_gnt_i    (ibus_gnt),
        .ibus_rvalid_i (ibus_rvalid),
        .ibus_rdata_i  (ibus_rdata),
        .ibus_err_i    (ibus_err),
        .stall_req_o   (stall_req),
        .inst_o        (inst),
        .inst_addr_o   (inst_addr),
        .inst_valid_o  (inst_valid),
        .inst_err_o    (inst_err)
    );

    // One cycle: inputs driven after the falling edge, then the combinational
    // outputs for these inputs and the IF/ID registers from the previous edge.
    typedef struct {
        logic [31:0] pc;
        logic        jmp;
        logic [2:0]  hold;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rerr;
        logic        req;
        logic        stall;
        logic [31:0] inst;
        logic [31:0] iaddr;
        logic        ival;
        logic        ierr;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] d(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] p, input logic j, input logic [2:0] h,
                       input logic g, input logic rv, input logic [31:0] rd, input logic re,
                       input logic req, input logic st, input logic [31:0] ins,
                       input logic [31:0] ia, input logic iv, input logic ie);
        vec_t v;
        v.pc = p; v.jmp = j; v.hold = h; v.gnt = g; v.rv = rv; v.rdata = rd; v.rerr = re;
        v.req = req; v.stall = st; v.inst = ins; v.iaddr = ia; v.ival = iv; v.ierr = ie;
        vecs.push_back(v);
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        pc          = v.pc;
        jump_flag   = v.jmp;
        hold_flag   = v.hold;
        ibus_gnt    = v.gnt;
        ibus_rvalid = v.rv;
        ibus_rdata  = v.rdata;
        ibus_err    = v.rerr;
        #1;
        check({tag, ".req"},   ibus_req,   v.req);
        check({tag, ".addr"},  ibus_addr,  v.pc);
        check({tag, ".stall"}, stall_req,  v.stall);
        check({tag, ".inst"},  inst,       v.inst);
        check({tag, ".iaddr"}, inst_addr,  v.iaddr);
        check({tag, ".valid"}, inst_valid, v.ival);
        check({tag, ".err"},   inst_err,   v.ierr);
    endtask

    task automatic run_table(input string prefix);
        for (int i = 0; i < vecs.size(); i++) apply($sformatf("%s%0d", prefix, i), vecs[i]);
    endtask

    task automatic idle_inputs();
        pc = '0; jump_flag = 1'b0; hold_flag = HOLD_NONE;
        ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = XD; ibus_err = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst.inst",  inst,       NOP);
        check("rst.iaddr", inst_addr,  32'h0);
        check("rst.valid", inst_valid, 1'b0);
        check("rst.err",   inst_err,   1'b0);
        check("rst.req",   ibus_req,   1'b0);
        @(negedge clk);
        rst = 1'b1;

        //   pc        j  hold       g  rv rdata     e  req st inst      iaddr     v  e
        // zero-wait bus: 0x00, 0x04, 0x08 back to back
        add(32'h00, 0, HOLD_NONE, 1, 0, XD,       0, 1, 0, NOP,      32'h00, 0, 0);
        add(32'h04, 0, HOLD_NONE, 1, 1, d(32'h00),0, 1, 0, NOP,      32'h00, 0, 0);
        add(32'h08, 0, HOLD_NONE, 1, 1, d(32'h04),0, 1, 0, d(32'h00),32'h00, 1, 0);
        // grant withheld three cycles at 0x10
        add(32'h10, 0, HOLD_NONE, 0, 1, d(32'h08),0, 1, 1, d(32'h04),32'h04, 1, 0);
        add(32'h10, 0, HOLD_NONE, 0, 0, XD,       0, 1, 1, d(32'h08),32'h08, 1, 0);
        add(32'h10, 0, HOLD_NONE, 0, 0, XD,       0, 1, 1, NOP,      32'h08, 0, 0);
        add(32'h10, 0, HOLD_NONE, 1, 0, XD,       0, 1, 0, NOP,      32'h08, 0, 0);
        add(32'h14, 0, HOLD_NONE, 1, 1, d(32'h10),0, 1, 0, NOP,      32'h08, 0, 0);
        // two outstanding (0x20, 0x24) then a jump to 0x80
        add(32'h20, 0, HOLD_NONE, 1, 1, d(32'h14),0, 1, 0, d(32'h10),32'h10, 1, 0);
        add(32'h24, 0, HOLD_NONE, 1, 0, XD,       0, 1, 0, d(32'h14),32'h14, 1, 0);
        add(32'h28, 0, HOLD_NONE, 1, 0, XD,       0, 0, 1, NOP,      32'h14, 0, 0);
        add(32'h28, 1, HOLD_NONE, 0, 0, XD,       0, 0, 0, NOP,      32'h14, 0, 0);
        add(32'h80, 0, HOLD_NONE, 1, 1, d(32'h20),0, 0, 1, NOP,      32'h14, 0, 0);
        add(32'h80, 0, HOLD_NONE, 1, 1, d(32'h24),0, 1, 0, NOP,      32'h14, 0, 0);
        add(32'h84, 0, HOLD_NONE, 0, 1, d(32'h80),0, 1, 1, NOP,      32'h14, 0, 0);
        // decode holds (Hold_Id) four cycles while 0x30, 0x34 return
        add(32'h30, 0, HOLD_NONE, 1, 0, XD,       0, 1, 0, d(32'h80),32'h80, 1, 0);
        add(32'h34, 0, HOLD_ID,   1, 0, XD,       0, 1, 0, NOP,      32'h80, 0, 0);
        add(32'h38, 0, HOLD_ID,   0, 1, d(32'h30),0, 0, 1, NOP,      32'h80, 0, 0);
        add(32'h38, 0, HOLD_ID,   0, 1, d(32'h34),0, 0, 1, NOP,      32'h80, 0, 0);
        add(32'h38, 0, HOLD_ID,   1, 0, XD,       0, 0, 1, NOP,      32'h80, 0, 0);
        add(32'h38, 0, HOLD_NONE, 1, 0, XD,       0, 0, 1, NOP,      32'h80, 0, 0);
        add(32'h38, 0, HOLD_NONE, 1, 0, XD,       0, 1, 0, d(32'h30),32'h30, 1, 0);
        // bus error on 0x40
        add(32'h40, 0, HOLD_NONE, 1, 1, d(32'h38),0, 1, 0, d(32'h34),32'h34, 1, 0);
        add(32'h44, 0, HOLD_NONE, 1, 1, d(32'h40),1, 1, 0, d(32'h38),32'h38, 1, 0);
        add(32'h48, 0, HOLD_NONE, 0, 1, d(32'h44),0, 1, 1, d(32'h40),32'h40, 1, 1);
        add(32'h48, 0, HOLD_NONE, 0, 0, XD,       0, 1, 1, d(32'h44),32'h44, 1, 0);
        // hold boundary: Hold_Pc advances, Hold_If freezes; buffer drains while a new response lands
        add(32'h48, 0, HOLD_PC,   1, 0, XD,       0, 1, 0, NOP,      32'h44, 0, 0);
        add(32'h4C, 0, HOLD_IF,   1, 0, XD,       0, 1, 0, NOP,      32'h44, 0, 0);
        add(32'h50, 0, HOLD_IF,   0, 1, d(32'h48),0, 0, 1, NOP,      32'h44, 0, 0);
        add(32'h50, 0, HOLD_PC,   0, 1, d(32'h4C),0, 0, 1, NOP,      32'h44, 0, 0);
        add(32'h50, 0, HOLD_NONE, 0, 0, XD,       0, 1, 1, d(32'h48),32'h48, 1, 0);
        add(32'h50, 0, HOLD_NONE, 0, 0, XD,       0, 1, 1, d(32'h4C),32'h4C, 1, 0);
        add(32'h50, 0, HOLD_NONE, 0, 0, XD,       0, 1, 1, NOP,      32'h4C, 0, 0);
        // jump under hold with a live response in the same cycle
        add(32'h60, 0, HOLD_NONE, 1, 0, XD,       0, 1, 0, NOP,      32'h4C, 0, 0);
        add(32'h64, 0, HOLD_NONE, 1, 0, XD,       0, 1, 0, NOP,      32'h4C, 0, 0);
        add(32'h64, 1, HOLD_ID,   0, 1, d(32'h60),0, 0, 0, NOP,      32'h4C, 0, 0);
        add(32'h90, 0, HOLD_NONE, 1, 0, XD,       0, 1, 0, NOP,      32'h4C, 0, 0);
        add(32'h94, 0, HOLD_NONE, 0, 1, d(32'h64),0, 0, 1, NOP,      32'h4C, 0, 0);
        add(32'h94, 0, HOLD_NONE, 0, 1, d(32'h90),0, 1, 1, NOP,      32'h4C, 0, 0);
        add(32'h94, 0, HOLD_NONE, 0, 0, XD,       0, 1, 1, d(32'h90),32'h90, 1, 0);
        // set up two outstanding reads with a valid instruction held in IF/ID
        add(32'hA0, 0, HOLD_NONE, 1, 0, XD,       0, 1, 0, NOP,      32'h90, 0, 0);
        add(32'hA4, 0, HOLD_NONE, 1, 1, d(32'hA0),0, 1, 0, NOP,      32'h90, 0, 0);
        add(32'hA8, 0, HOLD_ID,   1, 0, XD,       0, 1, 0, d(32'hA0),32'hA0, 1, 0);
        run_table("v");

        // Reset mid-transaction: outputs return to reset values at once.
        @(negedge clk);
        idle_inputs();
        pc  = 32'hAC;
        rst = 1'b0;
        #1;
        check("midrst.inst",  inst,       NOP);
        check("midrst.iaddr", inst_addr,  32'h0);
        check("midrst.valid", inst_valid, 1'b0);
        check("midrst.err",   inst_err,   1'b0);
        check("midrst.req",   ibus_req,   1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("postrst.req",   ibus_req,   1'b1);
        check("postrst.valid", inst_valid, 1'b0);

        // After reset the old reads are forgotten: 0xC0 is delivered, not 0xA4.
        vecs.delete();
        add(32'hC0, 0, HOLD_NONE, 1, 0, XD,       0, 1, 0, NOP,      32'h00, 0, 0);
        add(32'hC4, 0, HOLD_NONE, 0, 1, d(32'hC0),0, 1, 1, NOP,      32'h00, 0, 0);
        add(32'hC4, 0, HOLD_NONE, 0, 0, XD,       0, 1, 1, d(32'hC0),32'hC0, 1, 0);
        run_table("p");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_if_fetch
